// File: rtl/score_ssd_driver.sv
// Score display driver: binary score -> 4 BCD digits (double-dabble) -> multiplexed 7-segment scan.
// Latency: 16 clk from a score change to new display digits (capture, 14 shifts, latch); scan outputs registered (+1 clk).
// Backpressure: none; a score change mid-conversion is picked up by a fresh conversion once the current one latches.
//
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   score     - unsigned binary score, synchronous to clk
//   anode     - digit enables, active low, bit 0 = units digit
//   ssdOut    - segments {a,b,c,d,e,f,g} in [6:0], active low
//   conv_busy - high while a BCD conversion is in flight
module score_ssd_driver #(
    parameter int SCAN_BITS     = 18,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] score,
    output logic [3:0]  anode,
    output logic [6:0]  ssdOut,
    output logic        conv_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Active-low segment pattern for one BCD digit; non-BCD codes blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: a nibble that will reach >= 10 after the shift gets +3 first.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Conversion state
    state_t         state_q, state_d;
    logic           first_q, first_d;     // forces one conversion right after reset release
    logic [15:0]    sampled_q, sampled_d;
    logic [13:0]    bin_q, bin_d;         // 9999 fits in 14 bits
    logic [15:0]    bcd_q, bcd_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    digits_q, digits_d;   // displayed digits, only updated in LATCH
    logic           busy_q, busy_d;

    // Scan state
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [3:0]           anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;

    logic [13:0] sat;
    logic [15:0] bcd_adj;
    logic [1:0]  slot;
    logic [3:0]  slot_digit;
    logic        z1, z2, z3;
    logic        blank;

    assign sat = (score > 16'd9999) ? 14'd9999 : score[13:0];

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        sampled_d = sampled_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        busy_d    = busy_q;
        bcd_adj   = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

        case (state_q)
            IDLE: begin
                if (first_q || (score != sampled_q)) begin
                    first_d   = 1'b0;
                    sampled_d = score;
                    bin_d     = sat;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // {bcd, bin} <<= 1 after the per-nibble correction
                bcd_d = {bcd_adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                digits_d = bcd_q;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        scan_d     = scan_q + SCAN_BITS'(1);
        slot       = scan_q[SCAN_BITS-1 -: 2];
        z1         = (digits_q[7:4]   == 4'd0);
        z2         = (digits_q[11:8]  == 4'd0);
        z3         = (digits_q[15:12] == 4'd0);
        slot_digit = 4'd0;
        blank      = 1'b0;

        // A digit is blank only when it and every higher digit are zero; units always shown.
        case (slot)
            2'd0: begin slot_digit = digits_q[3:0];   blank = 1'b0;           end
            2'd1: begin slot_digit = digits_q[7:4];   blank = z3 & z2 & z1;   end
            2'd2: begin slot_digit = digits_q[11:8];  blank = z3 & z2;        end
            default: begin slot_digit = digits_q[15:12]; blank = z3;          end
        endcase

        if (BLANK_LEADING && blank) begin
            anode_d = 4'b1111;
            seg_d   = 7'b1111111;
        end else begin
            anode_d = ~(4'b0001 << slot);
            seg_d   = seg_encode(slot_digit);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            first_q   <= 1'b1;
            sampled_q <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            busy_q    <= 1'b0;
            scan_q    <= '0;
            anode_q   <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            sampled_q <= sampled_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            busy_q    <= busy_d;
            scan_q    <= scan_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign anode     = anode_q;
    assign ssdOut    = seg_q;
    assign conv_busy = busy_q;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Self-checking bench for score_ssd_driver with SCAN_BITS=4 (16-cycle scan, 4 cycles per slot).
// Table of scores with hand-computed per-slot anode/segment patterns, plus sequences for
// a mid-conversion score change and an asynchronous reset during SHIFT.
module tb_score_ssd_driver;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef struct {
        logic [15:0]      score;
        logic [3:0][3:0]  an;   // expected anode per slot, [3] = thousands
        logic [3:0][6:0]  seg;  // expected segments per slot
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] score;
    logic [3:0]  anode;
    logic [6:0]  ssdOut;
    logic        conv_busy;

    int n_chk;
    int n_fail;
    int cyc;
    vec_t vecs[12];

    score_ssd_driver #(
        .SCAN_BITS     (4),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .score     (score),
        .anode     (anode),
        .ssdOut    (ssdOut),
        .conv_busy (conv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since reset release; locates the scan slot.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic vec_t mk(input logic [15:0] s, input logic [15:0] an, input logic [27:0] seg);
        vec_t v;
        v.score = s;
        v.an    = an;
        v.seg   = seg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Samples n consecutive cycles on the falling edge and compares the active slot.
    task automatic check_display(input int idx, input int n);
        int d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = ((cyc - 1) & 15) >> 2;
            chk($sformatf("anode v%0d slot%0d", idx, d), {28'd0, anode}, {28'd0, vecs[idx].an[d]});
            chk($sformatf("ssdOut v%0d slot%0d", idx, d), {25'd0, ssdOut}, {25'd0, vecs[idx].seg[d]});
        end
    endtask

    // Apply a score on a falling edge and follow the full 16-cycle conversion, then the scan.
    task automatic run_vec(input int idx);
        reset_n = 1'b1;
        score   = vecs[idx].score;
        @(negedge clk);
        chk($sformatf("busy start v%0d", idx), {31'd0, conv_busy}, 32'd1);
        repeat (14) @(negedge clk);
        chk($sformatf("busy last shift v%0d", idx), {31'd0, conv_busy}, 32'd1);
        @(negedge clk);
        chk($sformatf("busy after latch v%0d", idx), {31'd0, conv_busy}, 32'd0);
        check_display(idx, 16);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        vecs[0]  = mk(16'd0,     {4'hF, 4'hF, 4'hF, 4'hE}, {SB, SB, SB, S0});
        vecs[1]  = mk(16'd1234,  AN_ALL,                   {S1, S2, S3, S4});
        vecs[2]  = mk(16'd1005,  AN_ALL,                   {S1, S0, S0, S5});
        vecs[3]  = mk(16'hFFFF,  AN_ALL,                   {S9, S9, S9, S9});
        vecs[4]  = mk(16'd10000, AN_ALL,                   {S9, S9, S9, S9});
        vecs[5]  = mk(16'd9999,  AN_ALL,                   {S9, S9, S9, S9});
        vecs[6]  = mk(16'd7,     {4'hF, 4'hF, 4'hF, 4'hE}, {SB, SB, SB, S7});
        vecs[7]  = mk(16'd80,    {4'hF, 4'hF, 4'hD, 4'hE}, {SB, SB, S8, S0});
        vecs[8]  = mk(16'd608,   {4'hF, 4'hB, 4'hD, 4'hE}, {SB, S6, S0, S8});
        vecs[9]  = mk(16'd5090,  AN_ALL,                   {S5, S0, S9, S0});
        vecs[10] = mk(16'd42,    {4'hF, 4'hF, 4'hD, 4'hE}, {SB, SB, S4, S2});
        vecs[11] = mk(16'd77,    {4'hF, 4'hF, 4'hD, 4'hE}, {SB, SB, S7, S7});

        // Reset state
        reset_n = 1'b0;
        score   = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset anode", {28'd0, anode}, 32'hF);
        chk("reset ssdOut", {25'd0, ssdOut}, 32'h7F);
        chk("reset busy", {31'd0, conv_busy}, 32'd0);

        // Table: vector 0 releases reset and relies on the first-cycle conversion rule.
        for (int i = 0; i < 10; i++) begin
            run_vec(i);
        end

        // Asynchronous reset in the middle of SHIFT while 5090 (all slots lit) is displayed.
        score = 16'd1234;
        repeat (6) @(negedge clk);
        chk("busy mid shift", {31'd0, conv_busy}, 32'd1);
        chk("lit before reset", {31'd0, (anode == 4'hF)}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst anode", {28'd0, anode}, 32'hF);
        chk("async rst ssdOut", {25'd0, ssdOut}, 32'h7F);
        chk("async rst busy", {31'd0, conv_busy}, 32'd0);
        repeat (2) @(negedge clk);
        run_vec(1);

        // Score 42 -> 77 during SHIFT: 42 latches intact, then a second conversion shows 77.
        score = vecs[10].score;
        repeat (5) @(negedge clk);
        score = vecs[11].score;
        repeat (10) @(negedge clk);
        chk("chg busy last shift", {31'd0, conv_busy}, 32'd1);
        @(negedge clk);
        chk("chg busy low", {31'd0, conv_busy}, 32'd0);
        @(negedge clk);
        chk("chg busy restart", {31'd0, conv_busy}, 32'd1);
        check_display(10, 15);
        chk("chg busy second latch", {31'd0, conv_busy}, 32'd0);
        check_display(11, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
